// File: rtl/register_file_pkg.sv
// Shared constants for the 8 x 8-bit general-purpose register file.
package register_file_pkg;

   localparam int DATA_W   = 8;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   // R0 is hardwired to zero. Writes to it are dropped and reads return 0.
   localparam int ZERO_REG = 0;

endpackage : register_file_pkg

// File: rtl/register_file_read_port.sv
// Combinational read port: a NUM_REGS:1 mux that forces the zero register
// to read as 0. Registers that have not been written are not propagated
// through R0, so R0 can never show X.
module regfile_read_port
   import register_file_pkg::*;
#(
   parameter int DATA_W = register_file_pkg::DATA_W,
   parameter int ADDR_W = register_file_pkg::ADDR_W
) (
   input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]                  addr,
   output logic [DATA_W-1:0]                  data
);

   // Zero-cycle read that ignores whatever R0's storage slot holds.
   always_comb begin
      data = '0;
      if (addr != ADDR_W'(ZERO_REG)) data = regs[addr];
   end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 8-entry register file with two asynchronous read ports and one
// synchronous write port. R0 reads as zero.
//
// Reads are not bypassed. A read of the register being written shows the
// old value until the clock edge, and the new value after it.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_W = register_file_pkg::DATA_W,
   parameter int ADDR_W = register_file_pkg::ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] AA,
   input  logic [ADDR_W-1:0] BA,
   input  logic [ADDR_W-1:0] DA,
   input  logic [DATA_W-1:0] DataIn,
   input  logic              WR,
   output logic [DATA_W-1:0] DataA,
   output logic [DATA_W-1:0] DataB
);

   logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs;
   logic                               wr_en;

   // A write to the zero register is discarded here. The read ports also
   // mask R0, so its storage slot is never relied upon.
   assign wr_en = WR && (DA != ADDR_W'(ZERO_REG));

   // Storage. Reset is synchronous and takes priority over a write on the same edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         regs <= '0;
      end else if (wr_en) begin
         regs[DA] <= DataIn;
      end
   end

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_a (
      .regs (regs),
      .addr (AA),
      .data (DataA)
   );

   regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_port_b (
      .regs (regs),
      .addr (BA),
      .data (DataB)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, hand-written
// corner sequences, then random traffic against an array model.
module tb_register_file;

   logic       Clk = 1'b0;
   logic       Reset, WR;
   logic [2:0] AA, BA, DA;
   logic [7:0] DataIn, DataA, DataB;

   int errors = 0;
   int checks = 0;

   // Reference model: one integer per register. Index 0 is never written.
   int mdl [8];

   typedef struct {
      logic       rst;
      logic       wr;
      logic [2:0] aa;
      logic [2:0] ba;
      logic [2:0] da;
      logic [7:0] din;
      logic [7:0] ea;
      logic [7:0] eb;
   } vec_t;

   vec_t tbl[$];

   register_file dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .AA     (AA),
      .BA     (BA),
      .DA     (DA),
      .DataIn (DataIn),
      .WR     (WR),
      .DataA  (DataA),
      .DataB  (DataB)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void add(input logic r, input logic w, input logic [2:0] a,
                               input logic [2:0] b, input logic [2:0] d,
                               input logic [7:0] di, input logic [7:0] ea,
                               input logic [7:0] eb);
      vec_t v;
      v.rst = r; v.wr = w; v.aa = a; v.ba = b; v.da = d; v.din = di;
      v.ea = ea; v.eb = eb;
      tbl.push_back(v);
   endfunction

   function automatic logic [7:0] mread(input logic [2:0] a);
      return (a == 3'd0) ? 8'h00 : 8'(mdl[a]);
   endfunction

   // Advance the model by one rising edge, using the spec's rules.
   function automatic void medge(input logic r, input logic w, input logic [2:0] d,
                                 input logic [7:0] di);
      if (r) begin
         for (int i = 0; i < 8; i++) mdl[i] = 0;
      end else if (w && d != 3'd0) begin
         mdl[d] = int'(di);
      end
   endfunction

   // Apply the inputs, check the pre-edge reads, then clock once.
   task automatic apply(input logic r, input logic w, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic [7:0] di,
                        input logic [7:0] ea, input logic [7:0] eb, input string nm);
      Reset = r; WR = w; AA = a; BA = b; DA = d; DataIn = di;
      #1;
      chk($sformatf("%s DataA aa=%0d", nm, a), DataA, ea);
      chk($sformatf("%s DataB ba=%0d", nm, b), DataB, eb);
      @(posedge Clk);
      medge(r, w, d, di);
      #1;
   endtask

   initial begin
      Reset = 1'b0; WR = 1'b0; AA = '0; BA = '0; DA = '0; DataIn = '0;
      for (int i = 0; i < 8; i++) mdl[i] = 0;

      // Hand sequence: one reset edge, then every address reads zero.
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         AA = 3'(i); BA = 3'(7 - i);
         #1;
         chk($sformatf("post-reset DataA aa=%0d", i), DataA, 8'h00);
         chk($sformatf("post-reset DataB ba=%0d", 7 - i), DataB, 8'h00);
      end

      // Directed table. Each row's expectations are the reads before its edge.
      for (int i = 1; i < 8; i++)          // fill R1..R7 with 0x11..0x17
         add(0, 1, 3'd0, 3'd0, 3'(i), 8'(8'h10 + i), 8'h00, 8'h00);
      for (int i = 1; i < 8; i++)          // sweep both ports
         add(0, 0, 3'(i), 3'(8 - i), 3'd0, 8'h00, 8'(8'h10 + i), 8'(8'h18 - i));
      add(0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
      add(0, 1, 3'd0, 3'd0, 3'd0, 8'hAA, 8'h00, 8'h00);   // write to R0 is dropped
      add(0, 0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00);
      for (int i = 1; i < 8; i++)          // R1..R7 unchanged
         add(0, 0, 3'(i), 3'(i), 3'd0, 8'h00, 8'(8'h10 + i), 8'(8'h10 + i));
      for (int i = 0; i < 3; i++)          // WR=0 holds R3
         add(0, 0, 3'd3, 3'd3, 3'd3, 8'hFF, 8'h13, 8'h13);
      add(0, 0, 3'd3, 3'd3, 3'd0, 8'h00, 8'h13, 8'h13);
      add(0, 1, 3'd5, 3'd5, 3'd5, 8'h5A, 8'h15, 8'h15);   // old value before the edge
      add(0, 0, 3'd5, 3'd5, 3'd0, 8'h00, 8'h5A, 8'h5A);   // new value after the edge
      add(1, 1, 3'd2, 3'd2, 3'd2, 8'h99, 8'h12, 8'h12);   // reset beats write
      for (int i = 1; i < 8; i++)
         add(0, 0, 3'(i), 3'(7 - i), 3'd0, 8'h00, 8'h00, 8'h00);

      foreach (tbl[k])
         apply(tbl[k].rst, tbl[k].wr, tbl[k].aa, tbl[k].ba, tbl[k].da, tbl[k].din,
               tbl[k].ea, tbl[k].eb, $sformatf("vec%0d", k));

      // Random traffic against the model, with occasional resets.
      for (int n = 0; n < 400; n++) begin
         logic       r, w;
         logic [2:0] a, b, d;
         logic [7:0] di;
         r  = ($urandom_range(0, 31) == 0);
         w  = $urandom_range(0, 1) == 1;
         a  = 3'($urandom_range(0, 7));
         b  = 3'($urandom_range(0, 7));
         d  = 3'($urandom_range(0, 7));
         di = 8'($urandom_range(0, 255));
         apply(r, w, a, b, d, di, mread(a), mread(b), "rand");
      end

      // Make sure R4 holds a known nonzero value before the mid-cycle check.
      apply(0, 1, 3'd0, 3'd0, 3'd4, 8'hC3, 8'h00, 8'h00, "seed");

      // Reset raised between edges must not change anything until the edge.
      @(negedge Clk);
      WR = 1'b0; AA = 3'd4; BA = 3'd4; Reset = 1'b1;
      #1;
      chk("mid-cycle reset DataA", DataA, mread(3'd4));
      chk("mid-cycle reset DataB", DataB, 8'hC3);
      @(posedge Clk);
      medge(1, 0, 3'd0, 8'h00);
      #1;
      Reset = 1'b0;
      chk("after reset edge DataA", DataA, 8'h00);
      chk("after reset edge DataB", DataB, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- 8-entry x 8-bit general-purpose register file for the 8-bit microprocessor datapath.
- Two independent asynchronous read ports, A and B, feed the ALU operands.
- One synchronous write port takes data from the result bus.
- R0 is a hardwired zero register.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, address width; the register count is 2**ADDR_W (8).

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset; clears all registers.
- AA  input  ADDR_W  read address, port A.
- BA  input  ADDR_W  read address, port B. Upper bits driven by a wider source are ignored; only bits [ADDR_W-1:0] are used.
- DA  input  ADDR_W  write (destination) address.
- DataIn  input  DATA_W  write data.
- WR  input  1  write enable, active-high.
- DataA  output  DATA_W  contents of register AA.
- DataB  output  DATA_W  contents of register BA.

Behaviour:
- Storage: registers R0..R7, each DATA_W bits.
- Reset:
  - At a rising Clk edge with Reset=1, R1..R7 become 0x00.
  - Reset has priority over a simultaneous write.
  - Reset is not asynchronous: asserting Reset between edges changes nothing until the next edge.
- Write:
  - At a rising Clk edge with Reset=0, WR=1 and DA!=0, R[DA] <= DataIn.
  - With WR=0, no register changes.
  - A write with DA=0 is discarded.
- R0: always reads 0x00, regardless of writes or reset.
- Read:
  - Purely combinational, zero-cycle latency.
  - DataA = R[AA] and DataB = R[BA], with R0 forced to 0x00.
  - Outputs update within the same cycle as the address changes.
- Read-during-write (same address):
  - Before the edge, the read port shows the old value.
  - After the edge, it shows the new value.
  - No write-to-read bypass.
- Both read ports may address the same register, or the register being written, simultaneously. There are no conflicts.
- Outputs after reset: DataA = DataB = 0x00 for every address.
- Register contents are unknown before the first reset. The design does not rely on power-up initial values.
- No X propagation from unwritten registers once reset has been applied.

Decomposition:
- Shared package: DATA_W and ADDR_W constants, NUM_REGS = 2**ADDR_W, and a zero-register index constant (0).
- One natural sub-module: regfile_read_port, a combinational NUM_REGS:1 mux with R0 zero-forcing. It is instantiated twice, for ports A and B.
- The storage array and write decode live in the top module.

Test Plan:
- Reset=1 for one edge, then sweep AA=0..7 and BA=0..7 -> DataA = DataB = 0x00 everywhere.
- Write phase: WR=1, DA=1..7 with DataIn=0x11..0x17, one write per edge. Then WR=0 and sweep AA=1..7 -> DataA = 0x11..0x17. Sweep BA=1..7 -> DataB = 0x11..0x17. AA=BA=0 -> 0x00.
- WR=1, DA=0, DataIn=0xAA -> AA=0 still reads 0x00, and R1..R7 are unchanged.
- WR=0, DA=3, DataIn=0xFF over several edges -> R3 remains 0x13.
- Same-cycle conflict: WR=1, DA=5, DataIn=0x5A, AA=BA=5. Before the edge, DataA = DataB = 0x15. After the edge, both are 0x5A.
- Reset with WR=1, DA=2, DataIn=0x99 on the same edge -> all registers 0x00, R2 not written. After deasserting Reset, sweep AA=1..7 -> all 0x00.
